loop_stim_driver: RTL and testbench

// Stimulus/measurement front end for the combinational feedback-loop test blocks. Accepts
// 8-bit input vectors on a valid/ready stream and drives each vector onto the loop inputs
// (w_003_001..w_003_008 order, bit 0 = w_003_001). Holds the vector for a settle window and

---
 rtl/loop_stim_if.sv | 29 ++
 rtl/loop_stim_driver.sv | 135 +++++++++++++
 tb/tb_loop_stim_driver.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/loop_stim_if.sv
// Stream bundle between a stimulus source/result sink and the loop stimulus driver.
// The master side feeds vectors and the loop net; the slave side is the driver itself.
interface loop_stim_if #(
  parameter int VEC_W = 8,
  parameter int CNT_W = 5
);
  logic             s_valid;
  logic             s_ready;
  logic [VEC_W-1:0] s_vec;
  logic [VEC_W-1:0] drv_vec;
  logic             loop_net;
  logic             busy;
  logic             r_valid;
  logic             r_ready;
  logic [VEC_W-1:0] r_vec;
  logic [CNT_W-1:0] r_toggles;
  logic             r_osc;
  logic             r_final;

  modport master (
    output s_valid, s_vec, loop_net, r_ready,
    input  s_ready, drv_vec, busy, r_valid, r_vec, r_toggles, r_osc, r_final
  );

  modport slave (
    input  s_valid, s_vec, loop_net, r_ready,
    output s_ready, drv_vec, busy, r_valid, r_vec, r_toggles, r_osc, r_final
  );
endinterface

// File: rtl/loop_stim_driver.sv
// Drives stimulus vectors onto a feedback-loop block and counts transitions of one
// asynchronous loop net over a settle window, returning one result per vector.
//
// state  | meaning
// IDLE   | waiting for a vector, s_ready high
// APPLY  | vector driven, two cycles to flush the synchronizer
// SETTLE | SETTLE_CYC cycles of toggle counting
// REPORT | result held until the consumer takes it
module loop_stim_driver #(
  parameter int VEC_W      = 8,
  parameter int SETTLE_CYC = 16,
  parameter int OSC_THRESH = 2,
  parameter int CNT_W      = 5
) (
  input logic        clk,
  input logic        rst_n,
  loop_stim_if.slave bus
);

  typedef enum logic [1:0] {IDLE, APPLY, SETTLE, REPORT} state_t;

  localparam int PH_W = $clog2(SETTLE_CYC + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           state_nxt;
  logic [PH_W-1:0]  phase;
  logic             sync1;
  logic             sync2;
  logic             prev;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [VEC_W-1:0] drv_vec;
  logic [CNT_W-1:0] r_toggles;
  logic             r_osc;
  logic             r_final;
  logic             toggle;
  logic             accept;
  logic             handshake;
  logic             apply_done;
  logic             settle_done;
  logic             s_ready;
  logic             busy;
  logic             r_valid;

  assign toggle      = sync2 ^ prev;
  assign apply_done  = (state == APPLY) && (phase == PH_W'(1));
  assign settle_done = (state == SETTLE) && (phase == PH_W'(SETTLE_CYC - 1));
  assign accept      = bus.s_valid & s_ready;
  assign handshake   = r_valid & bus.r_ready;
  // Counter sticks at all-ones so long oscillations never wrap to a small count.
  assign cnt_inc     = (toggle && (cnt != CNT_MAX)) ? cnt + 1'b1 : cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)      state_nxt = APPLY;
      APPLY:   if (apply_done)  state_nxt = SETTLE;
      SETTLE:  if (settle_done) state_nxt = REPORT;
      REPORT:  if (handshake)   state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_ready = 1'b0;
    busy    = 1'b0;
    r_valid = 1'b0;
    case (state)
      IDLE:    s_ready = rst_n;
      APPLY:   busy    = 1'b1;
      SETTLE:  busy    = 1'b1;
      REPORT: begin
        busy    = 1'b1;
        r_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      prev      <= 1'b0;
      phase     <= '0;
      cnt       <= '0;
      drv_vec   <= '0;
      r_toggles <= '0;
      r_osc     <= 1'b0;
      r_final   <= 1'b0;
    end else begin
      sync1 <= bus.loop_net;
      sync2 <= sync1;
      prev  <= sync2;
      case (state)
        IDLE: begin
          if (accept) begin
            drv_vec <= bus.s_vec;
            cnt     <= '0;
            phase   <= '0;
          end
        end
        APPLY: begin
          phase <= apply_done ? '0 : phase + 1'b1;
        end
        SETTLE: begin
          cnt   <= cnt_inc;
          phase <= phase + 1'b1;
          if (settle_done) begin
            r_toggles <= cnt_inc;
            r_osc     <= (cnt_inc >= CNT_W'(OSC_THRESH));
            r_final   <= sync2;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.s_ready   = s_ready;
  assign bus.busy      = busy;
  assign bus.r_valid   = r_valid;
  assign bus.drv_vec   = drv_vec;
  assign bus.r_vec     = drv_vec;
  assign bus.r_toggles = r_toggles;
  assign bus.r_osc     = r_osc;
  assign bus.r_final   = r_final;

endmodule

// File: tb/tb_loop_stim_driver.sv
// Bench for loop_stim_driver: two instances (16- and 40-cycle settle windows) checked
// against a history-based model of the loop net as seen at each clock edge.
module tb_loop_stim_driver;
  localparam int VEC_W  = 8;
  localparam int CNT_W  = 5;
  localparam int HIST_N = 4096;
  localparam int SAT    = 31;
  localparam int THRESH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             sel;
  logic             s_valid;
  logic [VEC_W-1:0] s_vec;
  logic             loop_net;
  logic             r_ready;

  loop_stim_if #(.VEC_W(VEC_W), .CNT_W(CNT_W)) if_a ();
  loop_stim_if #(.VEC_W(VEC_W), .CNT_W(CNT_W)) if_b ();

  loop_stim_driver #(.VEC_W(VEC_W), .SETTLE_CYC(16), .OSC_THRESH(THRESH), .CNT_W(CNT_W))
    u_dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  loop_stim_driver #(.VEC_W(VEC_W), .SETTLE_CYC(40), .OSC_THRESH(THRESH), .CNT_W(CNT_W))
    u_dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

  assign if_a.s_valid  = s_valid & ~sel;
  assign if_a.s_vec    = s_vec;
  assign if_a.loop_net = loop_net;
  assign if_a.r_ready  = r_ready & ~sel;
  assign if_b.s_valid  = s_valid & sel;
  assign if_b.s_vec    = s_vec;
  assign if_b.loop_net = loop_net;
  assign if_b.r_ready  = r_ready & sel;

  logic             o_s_ready, o_busy, o_r_valid, o_r_osc, o_r_final;
  logic [VEC_W-1:0] o_drv_vec, o_r_vec;
  logic [CNT_W-1:0] o_r_toggles;
  assign o_s_ready   = sel ? if_b.s_ready   : if_a.s_ready;
  assign o_busy      = sel ? if_b.busy      : if_a.busy;
  assign o_r_valid   = sel ? if_b.r_valid   : if_a.r_valid;
  assign o_r_osc     = sel ? if_b.r_osc     : if_a.r_osc;
  assign o_r_final   = sel ? if_b.r_final   : if_a.r_final;
  assign o_drv_vec   = sel ? if_b.drv_vec   : if_a.drv_vec;
  assign o_r_vec     = sel ? if_b.r_vec     : if_a.r_vec;
  assign o_r_toggles = sel ? if_b.r_toggles : if_a.r_toggles;

  // Value of loop_net at every rising edge, indexed by edge number.
  int   cyc = 0;
  logic hist [HIST_N];
  always @(posedge clk) begin
    hist[cyc % HIST_N] <= loop_net;
    cyc <= cyc + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction: accept, watch latency, compare result with the model, drain.
  task automatic run_vec(input logic s, input logic [VEC_W-1:0] vec, input int mode,
                         input int hold);
    int settle;
    int e0;
    int n;
    int exp_t;
    logic exp_f;
    settle = s ? 40 : 16;
    @(posedge clk); #1;
    sel = s;
    if (mode < 2) loop_net = 1'b0;
    s_valid = 1'b1;
    s_vec   = vec;
    r_ready = 1'b0;
    chk("s_ready_idle", o_s_ready, 1);
    @(posedge clk); #1;
    e0 = cyc - 1;
    s_vec = ~vec;
    chk("drv_vec_accept", o_drv_vec, vec);
    chk("busy_accept", o_busy, 1);
    chk("s_ready_busy", o_s_ready, 0);
    n = 0;
    while (o_r_valid !== 1'b1 && n < 200) begin
      case (mode)
        1:       if (n == 2 + settle / 2) loop_net = 1'b1;
        2:       loop_net = ~loop_net;
        3:       loop_net = 1'($urandom_range(0, 1));
        default: ;
      endcase
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, 2 + settle);

    // Settle window covers the cycles begun by edges e0+2 .. e0+1+settle; in each,
    // the synchronized value is the net one edge back and the previous sample two back.
    exp_t = 0;
    for (int j = e0 + 2; j <= e0 + 1 + settle; j++)
      if (hist[(j - 1) % HIST_N] != hist[(j - 2) % HIST_N] && exp_t < SAT) exp_t++;
    exp_f = hist[(e0 + settle) % HIST_N];

    chk("r_vec", o_r_vec, vec);
    chk("r_toggles", o_r_toggles, exp_t);
    chk("r_osc", o_r_osc, (exp_t >= THRESH) ? 1 : 0);
    chk("r_final", o_r_final, exp_f);
    chk("s_ready_report", o_s_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_r_valid", o_r_valid, 1);
      chk("hold_s_ready", o_s_ready, 0);
      chk("hold_r_vec", o_r_vec, vec);
      chk("hold_r_toggles", o_r_toggles, exp_t);
      chk("hold_r_final", o_r_final, exp_f);
    end
    r_ready = 1'b1;
    @(posedge clk); #1;
    r_ready = 1'b0;
    s_valid = 1'b0;
    chk("post_r_valid", o_r_valid, 0);
    chk("post_s_ready", o_s_ready, 1);
    chk("post_busy", o_busy, 0);
    chk("post_drv_vec", o_drv_vec, vec);
  endtask

  initial begin
    int seen;
    sel = 1'b0; s_valid = 1'b0; s_vec = '0; loop_net = 1'b0; r_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", o_s_ready, 0);
    chk("rst_drv_vec", o_drv_vec, 0);
    chk("rst_r_valid", o_r_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_r_toggles", o_r_toggles, 0);
    chk("rst_r_osc", o_r_osc, 0);
    chk("rst_r_final", o_r_final, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_release_s_ready", o_s_ready, 1);

    run_vec(1'b0, 8'hA5, 0, 0);
    chk("quiet_toggles", o_r_toggles, 0);
    chk("quiet_final", o_r_final, 0);

    run_vec(1'b0, 8'h3C, 1, 0);
    chk("step_toggles", o_r_toggles, 1);
    chk("step_osc", o_r_osc, 0);
    chk("step_final", o_r_final, 1);

    run_vec(1'b0, 8'h5A, 2, 0);
    chk("osc16_toggles", o_r_toggles, 16);
    chk("osc16_osc", o_r_osc, 1);

    run_vec(1'b1, 8'hC3, 2, 0);
    chk("sat40_toggles", o_r_toggles, SAT);
    chk("sat40_osc", o_r_osc, 1);

    run_vec(1'b0, 8'h96, 0, 5);

    // Reset in the middle of the settle window abandons the vector.
    @(posedge clk); #1;
    sel = 1'b0; loop_net = 1'b0; s_valid = 1'b1; s_vec = 8'h77;
    @(posedge clk); #1;
    s_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("mid_busy", o_busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_drv_vec", o_drv_vec, 0);
    chk("midrst_r_valid", o_r_valid, 0);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_s_ready", o_s_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("midrst_release_s_ready", o_s_ready, 1);
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (o_r_valid !== 1'b0) seen++;
    end
    chk("no_stale_result", seen, 0);

    for (int k = 0; k < 10; k++)
      run_vec(1'($urandom_range(0, 1)), VEC_W'($urandom), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
